// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/data requesters, the arbiter and the
// single-ported backing memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              en;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;
    logic [31:0]       m_rdata;

    modport slave (
        input  en, i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_req, m_we, m_addr, m_wdata, m_wstrb
    );

    modport master (
        output en, i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_req, m_we, m_addr, m_wdata, m_wstrb
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data requesters; data wins
// by default, a starvation counter bounds how long fetch is held off.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int              SC_W   = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);
    localparam logic [SC_W-1:0] SC_ONE = SC_W'(1'b1);

    logic [SC_W-1:0]    sc_r;
    logic [MEM_LAT-1:0] tag_valid_r;
    logic [MEM_LAT-1:0] tag_src_d_r;
    logic               i_gnt_s;
    logic               d_gnt_s;
    logic               rd_push_s;

    // Grant selection: data first unless fetch has waited STARVE_MAX data grants.
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (rst || !bus.en) begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (bus.i_req && bus.d_req) begin
            if (sc_r == SC_MAX) begin
                i_gnt_s = 1'b1;
            end else begin
                d_gnt_s = 1'b1;
            end
        end else if (bus.i_req) begin
            i_gnt_s = 1'b1;
        end else if (bus.d_req) begin
            d_gnt_s = 1'b1;
        end else begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    assign rd_push_s = i_gnt_s | (d_gnt_s & ~bus.d_we);
    assign bus.i_gnt = i_gnt_s;
    assign bus.d_gnt = d_gnt_s;

    // Starvation counter: consecutive data grants while fetch is waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_r <= {SC_W{1'b0}};
        end else if (i_gnt_s || !bus.i_req) begin
            sc_r <= {SC_W{1'b0}};
        end else if (d_gnt_s) begin
            sc_r <= sc_r + SC_ONE;
        end else begin
            sc_r <= sc_r;
        end
    end

    // Memory command mux; idle cycles drive all zeros.
    always_comb begin
        bus.m_req   = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_addr  = {ADDR_W{1'b0}};
        bus.m_wdata = 32'h0000_0000;
        bus.m_wstrb = 4'b0000;
        if (i_gnt_s) begin
            bus.m_req  = 1'b1;
            bus.m_addr = bus.i_addr;
        end else if (d_gnt_s) begin
            bus.m_req   = 1'b1;
            bus.m_we    = bus.d_we;
            bus.m_addr  = bus.d_addr;
            bus.m_wdata = bus.d_wdata;
            bus.m_wstrb = bus.d_wstrb;
        end else begin
            bus.m_req = 1'b0;
        end
    end

    // Tag pipeline keeps running with en low so in-flight reads still drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_r <= {MEM_LAT{1'b0}};
            tag_src_d_r <= {MEM_LAT{1'b0}};
        end else begin
            tag_valid_r[0] <= rd_push_s;
            tag_src_d_r[0] <= d_gnt_s;
            for (int k = 1; k < MEM_LAT; k++) begin
                tag_valid_r[k] <= tag_valid_r[k-1];
                tag_src_d_r[k] <= tag_src_d_r[k-1];
            end
        end
    end

    assign bus.i_rvalid = tag_valid_r[MEM_LAT-1] & ~tag_src_d_r[MEM_LAT-1];
    assign bus.d_rvalid = tag_valid_r[MEM_LAT-1] &  tag_src_d_r[MEM_LAT-1];
    assign bus.i_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives three arbiters (MEM_LAT 1..3) with identical stimulus and checks each
// cycle against a history-based model, plus directed literal checks.
module tb_mem_port_arbiter;
    localparam int NL   = 3;
    localparam int SMAX = 4;
    localparam int HN   = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, en = 1'b1, i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0, m_rdata = 32'h0;
    logic [3:0]  d_wstrb = 4'h0;

    logic [NL-1:0] i_gnt_o, d_gnt_o, m_req_o, m_we_o, i_rvalid_o, d_rvalid_o;
    logic [31:0]   m_addr_o [NL];
    logic [31:0]   m_wdata_o [NL];
    logic [31:0]   i_rdata_o [NL];
    logic [31:0]   d_rdata_o [NL];
    logic [3:0]    m_wstrb_o [NL];

    for (genvar g = 0; g < NL; g++) begin : g_dut
        mem_port_arbiter_if #(.ADDR_W(32)) bus ();
        assign bus.en      = en;
        assign bus.i_req   = i_req;
        assign bus.i_addr  = i_addr;
        assign bus.d_req   = d_req;
        assign bus.d_we    = d_we;
        assign bus.d_addr  = d_addr;
        assign bus.d_wdata = d_wdata;
        assign bus.d_wstrb = d_wstrb;
        assign bus.m_rdata = m_rdata;
        assign i_gnt_o[g]    = bus.i_gnt;
        assign d_gnt_o[g]    = bus.d_gnt;
        assign m_req_o[g]    = bus.m_req;
        assign m_we_o[g]     = bus.m_we;
        assign i_rvalid_o[g] = bus.i_rvalid;
        assign d_rvalid_o[g] = bus.d_rvalid;
        assign m_addr_o[g]   = bus.m_addr;
        assign m_wdata_o[g]  = bus.m_wdata;
        assign i_rdata_o[g]  = bus.i_rdata;
        assign d_rdata_o[g]  = bus.d_rdata;
        assign m_wstrb_o[g]  = bus.m_wstrb;
        mem_port_arbiter #(.ADDR_W(32), .MEM_LAT(g + 1), .STARVE_MAX(SMAX)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: expected grants from the arbitration rules; read returns from a
    // per-cycle history of granted reads and reset cycles.
    int sc_m = 0;
    int cyc = 0;
    bit hist_rd [HN];
    bit hist_d [HN];
    bit hist_rst [HN];

    always @(negedge clk) begin
        bit          eg_i, eg_d, ev_i, ev_d, killed;
        int          lat, src;
        logic [69:0] exp_m;
        eg_i = 1'b0;
        eg_d = 1'b0;
        if (!rst && en) begin
            if (i_req && (!d_req || sc_m == SMAX)) eg_i = 1'b1;
            else if (d_req) eg_d = 1'b1;
        end
        if (eg_i)      exp_m = {1'b1, 1'b0, i_addr, 32'h0, 4'h0};
        else if (eg_d) exp_m = {1'b1, d_we, d_addr, d_wdata, d_wstrb};
        else           exp_m = 70'h0;
        for (int g = 0; g < NL; g++) begin
            lat  = g + 1;
            ev_i = 1'b0;
            ev_d = 1'b0;
            src  = cyc - lat;
            if (src >= 0 && src < HN && hist_rd[src]) begin
                killed = 1'b0;
                for (int k = src + 1; k < cyc; k++) if (hist_rst[k]) killed = 1'b1;
                if (!killed) begin
                    ev_i = !hist_d[src];
                    ev_d = hist_d[src];
                end
            end
            chk($sformatf("L%0d i_gnt", lat), i_gnt_o[g], eg_i);
            chk($sformatf("L%0d d_gnt", lat), d_gnt_o[g], eg_d);
            chk($sformatf("L%0d m_bus", lat),
                {m_req_o[g], m_we_o[g], m_addr_o[g], m_wdata_o[g], m_wstrb_o[g]}, exp_m);
            chk($sformatf("L%0d i_rvalid", lat), i_rvalid_o[g], ev_i);
            chk($sformatf("L%0d d_rvalid", lat), d_rvalid_o[g], ev_d);
            chk($sformatf("L%0d rdata", lat), {i_rdata_o[g], d_rdata_o[g]}, {m_rdata, m_rdata});
        end
        if (cyc < HN) begin
            hist_rd[cyc]  = eg_i || (eg_d && !d_we);
            hist_d[cyc]   = eg_d;
            hist_rst[cyc] = rst;
        end
        if (rst || eg_i || !i_req) sc_m = 0;
        else if (eg_d) sc_m = sc_m + 1;
        cyc++;
    end

    task automatic drive(input bit r, input bit e, input bit ir, input logic [31:0] ia,
                         input bit dr, input bit dwe, input logic [31:0] da,
                         input logic [31:0] dwd, input logic [3:0] dws, input logic [31:0] rd);
        @(posedge clk);
        #1;
        rst = r; en = e; i_req = ir; i_addr = ia; d_req = dr; d_we = dwe;
        d_addr = da; d_wdata = dwd; d_wstrb = dws; m_rdata = rd;
        #2;
    endtask

    task automatic idle(input logic [31:0] rd);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd);
    endtask

    initial begin
        string exp_seq;
        byte   got;
        exp_seq = "DDDDIDDDDI";

        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 1'b1, 32'h00400000, 1'b1, 1'b0, 32'h80000000, 32'h0, 4'h0, 32'h0);
            chk("reset no grant", {i_gnt_o[0], d_gnt_o[0], m_req_o[0]}, 80'h0);
        end
        drive(1'b0, 1'b1, 1'b1, 32'h00400000, 1'b1, 1'b0, 32'h80000000, 32'h0, 4'h0, 32'h0);
        chk("post-reset d_gnt", {i_gnt_o[0], d_gnt_o[0]}, 80'h1);

        idle(32'h0);
        drive(1'b0, 1'b1, 1'b1, 32'h00400000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        chk("lone fetch gnt", i_gnt_o[0], 80'h1);
        chk("lone fetch addr", m_addr_o[0], 80'h00400000);
        idle(32'h00100073);
        chk("lone fetch return", {i_rvalid_o[0], d_rvalid_o[0], i_rdata_o[0]}, {2'b10, 32'h00100073});

        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 1'b1, 32'h00400100, 1'b1, 1'b0, 32'h80000100, 32'h0, 4'h0, 32'h0);
            got = d_gnt_o[0] ? 8'h44 : (i_gnt_o[0] ? 8'h49 : 8'h2D);
            chk($sformatf("starve seq %0d", k), got, exp_seq[k]);
            chk("no double gnt", i_gnt_o[0] & d_gnt_o[0], 80'h0);
        end

        for (int k = 0; k < 3; k++) idle(32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h80000000, 32'h0, 4'h0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 32'h00400004, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80000008, 32'hCAFEF00D, 4'b0110, 32'h0);
        chk("mixed write cmd", {m_we_o[2], m_wstrb_o[2], m_addr_o[2]}, {1'b1, 4'b0110, 32'h80000008});
        idle(32'h11111111);
        chk("mixed d ret", {d_rvalid_o[2], i_rvalid_o[2]}, 80'h2);
        idle(32'h22222222);
        chk("mixed i ret", {d_rvalid_o[2], i_rvalid_o[2]}, 80'h1);
        idle(32'h0);
        chk("mixed no write ret", {d_rvalid_o[2], i_rvalid_o[2]}, 80'h0);

        idle(32'h0);
        drive(1'b0, 1'b1, 1'b1, 32'h00400010, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        chk("en read gnt", i_gnt_o[2], 80'h1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h00400014, 1'b1, 1'b0, 32'h80000020, 32'h0, 4'h0, 32'h33333333);
            chk("en=0 no grant", {i_gnt_o[2], d_gnt_o[2], m_req_o[2]}, 80'h0);
            if (k == 0) chk("en=0 drain L1", i_rvalid_o[0], 80'h1);
            if (k == 2) chk("en=0 drain L3", i_rvalid_o[2], 80'h1);
        end

        idle(32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h80000040, 32'h0, 4'h0, 32'h0);
        chk("midrst gnt", d_gnt_o[1], 80'h1);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        idle(32'h44444444);
        chk("midrst dropped L2", d_rvalid_o[1], 80'h0);
        idle(32'h55555555);
        chk("midrst dropped L3", d_rvalid_o[2], 80'h0);

        for (int k = 0; k < 2000; k++) begin
            drive(($urandom_range(127) == 0), ($urandom_range(15) != 0),
                  ($urandom_range(2) != 0), $urandom, ($urandom_range(2) != 0),
                  ($urandom_range(2) == 0), $urandom, $urandom, 4'($urandom_range(15)),
                  $urandom);
        end

        for (int k = 0; k < 5; k++) idle(32'h0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
